// File: rtl/call_stack.sv
// Return-address stack for the CPU control path: LIFO with status, sticky
// error flags, flush, same-cycle replace and selectable overflow policy.
module call_stack #(
    parameter int WIDTH    = 10,
    parameter int DEPTH    = 8,
    parameter int OVF_WRAP = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             flush,
    input  logic             clr_err,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_inc;
    logic [PW-1:0]    sp_dec;
    logic [PW-1:0]    sp_n;
    logic [CW-1:0]    count_n;
    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic             set_ovf;
    logic             set_unf;

    // Pointer wraps at DEPTH explicitly so non-power-of-two depths work.
    assign sp_inc = (sp == PW'(DEPTH - 1)) ? '0 : sp + PW'(1);
    assign sp_dec = (sp == '0) ? PW'(DEPTH - 1) : sp - PW'(1);

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign top   = empty ? '0 : mem[sp_dec];

    always_comb begin
        sp_n    = sp;
        count_n = count;
        wr_en   = 1'b0;
        wr_addr = sp;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (flush) begin
            sp_n    = '0;
            count_n = '0;
        end else if (push && pop) begin
            // Replace the top in place; on an empty stack this is a no-op.
            if (!empty) begin
                wr_en   = 1'b1;
                wr_addr = sp_dec;
            end
        end else if (push) begin
            if (!full) begin
                wr_en   = 1'b1;
                sp_n    = sp_inc;
                count_n = count + CW'(1);
            end else begin
                set_ovf = 1'b1;
                if (OVF_WRAP != 0) begin
                    wr_en = 1'b1;
                    sp_n  = sp_inc;
                end
            end
        end else if (pop) begin
            if (!empty) begin
                sp_n    = sp_dec;
                count_n = count - CW'(1);
            end else begin
                set_unf = 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            sp    <= sp_n;
            count <= count_n;
            ovf   <= set_ovf | (ovf & ~clr_err);
            unf   <= set_unf | (unf & ~clr_err);
        end
    end

endmodule

// File: tb/tb_call_stack.sv
// Scoreboard bench for call_stack: both overflow policies driven in lockstep
// and compared against an array-based stack model.
module tb_call_stack;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [9:0] din = '0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;

    logic [9:0] top0, top1;
    logic [3:0] count0, count1;
    logic       empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;

    int nChecks = 0;
    int nFail   = 0;
    string phase = "init";

    typedef struct {
        string      tag;
        int         cnt0;
        int         cnt1;
        logic [9:0] top0;
        logic [9:0] top1;
        bit         ovf0;
        bit         ovf1;
        bit         unf0;
        bit         unf1;
    } exp_t;

    exp_t expq[$];

    logic [9:0] mstk [2][8];
    int         mcnt [2];
    bit         movf [2];
    bit         munf [2];

    call_stack #(.WIDTH(10), .DEPTH(8), .OVF_WRAP(0)) u0 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .flush(flush), .clr_err(clr_err), .top(top0), .count(count0),
        .empty(empty0), .full(full0), .ovf(ovf0), .unf(unf0)
    );

    call_stack #(.WIDTH(10), .DEPTH(8), .OVF_WRAP(1)) u1 (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .flush(flush), .clr_err(clr_err), .top(top1), .count(count1),
        .empty(empty1), .full(full1), .ovf(ovf1), .unf(unf1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.tag  = phase;
        e.cnt0 = mcnt[0];
        e.cnt1 = mcnt[1];
        e.top0 = (mcnt[0] > 0) ? mstk[0][mcnt[0]-1] : 10'h000;
        e.top1 = (mcnt[1] > 0) ? mstk[1][mcnt[1]-1] : 10'h000;
        e.ovf0 = movf[0];
        e.ovf1 = movf[1];
        e.unf0 = munf[0];
        e.unf1 = munf[1];
        return e;
    endfunction

    // Stack model: index 0 is the oldest entry, mcnt entries are live.
    task automatic modelStep(input bit p, input bit po, input logic [9:0] d,
                             input bit f, input bit c);
        for (int m = 0; m < 2; m++) begin
            bit so = 1'b0;
            bit su = 1'b0;
            if (f) begin
                mcnt[m] = 0;
            end else if (p && po) begin
                if (mcnt[m] > 0) mstk[m][mcnt[m]-1] = d;
            end else if (p) begin
                if (mcnt[m] < 8) begin
                    mstk[m][mcnt[m]] = d;
                    mcnt[m]++;
                end else begin
                    so = 1'b1;
                    if (m == 1) begin
                        for (int k = 0; k < 7; k++) mstk[m][k] = mstk[m][k+1];
                        mstk[m][7] = d;
                    end
                end
            end else if (po) begin
                if (mcnt[m] > 0) mcnt[m]--;
                else su = 1'b1;
            end
            if (c) begin
                movf[m] = 1'b0;
                munf[m] = 1'b0;
            end
            if (so) movf[m] = 1'b1;
            if (su) munf[m] = 1'b1;
        end
    endtask

    task automatic applyStimulus(input bit p, input bit po, input logic [9:0] d,
                                 input bit f, input bit c);
        @(negedge clk);
        push    = p;
        pop     = po;
        din     = d;
        flush   = f;
        clr_err = c;
        modelStep(p, po, d, f, c);
        expq.push_back(snapshot());
    endtask

    // Reset lands mid-phase so the check happens before the next clock edge.
    task automatic doReset();
        @(negedge clk);
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        #2;
        reset = 1'b1;
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0;
            movf[m] = 1'b0;
            munf[m] = 1'b0;
        end
        expq.push_back(snapshot());
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                checkOutput({e.tag, " count0"}, int'(count0), e.cnt0);
                checkOutput({e.tag, " top0"},   int'(top0),   int'(e.top0));
                checkOutput({e.tag, " empty0"}, int'(empty0), int'(e.cnt0 == 0));
                checkOutput({e.tag, " full0"},  int'(full0),  int'(e.cnt0 == 8));
                checkOutput({e.tag, " ovf0"},   int'(ovf0),   int'(e.ovf0));
                checkOutput({e.tag, " unf0"},   int'(unf0),   int'(e.unf0));
                checkOutput({e.tag, " count1"}, int'(count1), e.cnt1);
                checkOutput({e.tag, " top1"},   int'(top1),   int'(e.top1));
                checkOutput({e.tag, " empty1"}, int'(empty1), int'(e.cnt1 == 0));
                checkOutput({e.tag, " full1"},  int'(full1),  int'(e.cnt1 == 8));
                checkOutput({e.tag, " ovf1"},   int'(ovf1),   int'(e.ovf1));
                checkOutput({e.tag, " unf1"},   int'(unf1),   int'(e.unf1));
            end
        end
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0;
            movf[m] = 1'b0;
            munf[m] = 1'b0;
            for (int k = 0; k < 8; k++) mstk[m][k] = '0;
        end

        phase = "reset";
        doReset();

        phase = "basic";
        for (int i = 1; i <= 3; i++) applyStimulus(1, 0, 10'(i), 0, 0);
        repeat (3) applyStimulus(0, 1, 10'h000, 0, 0);

        phase = "overflow";
        for (int i = 0; i < 9; i++) applyStimulus(1, 0, 10'h010 + 10'(i), 0, 0);
        repeat (8) applyStimulus(0, 1, 10'h000, 0, 0);
        applyStimulus(0, 0, 10'h000, 0, 1);

        phase = "wrap";
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 10'h020 + 10'(i), 0, 0);
        repeat (9) applyStimulus(0, 1, 10'h000, 0, 0);
        applyStimulus(0, 0, 10'h000, 0, 1);

        phase = "replace";
        applyStimulus(1, 0, 10'h100, 0, 0);
        applyStimulus(1, 0, 10'h101, 0, 0);
        applyStimulus(1, 1, 10'h1FF, 0, 0);
        repeat (2) applyStimulus(0, 1, 10'h000, 0, 0);
        applyStimulus(1, 1, 10'h155, 0, 0);

        phase = "flush";
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 10'h040 + 10'(i), 0, 0);
        applyStimulus(1, 0, 10'h3AA, 1, 0);
        applyStimulus(0, 1, 10'h000, 0, 0);
        applyStimulus(0, 1, 10'h000, 0, 1);
        applyStimulus(0, 0, 10'h000, 0, 1);

        phase = "async_reset";
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 10'h050 + 10'(i), 0, 0);
        doReset();

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                doReset();
            end else begin
                bit p, po, f, c;
                p  = ($urandom_range(0, 99) < 55);
                po = ($urandom_range(0, 99) < 45);
                f  = ($urandom_range(0, 99) < 3);
                c  = ($urandom_range(0, 99) < 6);
                applyStimulus(p, po, 10'($urandom), f, c);
            end
        end

        @(negedge clk);
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        if (expq.size() != 0) checkOutput("drain", expq.size(), 0);

        $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
        $finish;
    end

endmodule

// File: doc/call_stack.md
Name: call_stack

Overview:
- Parametrised LIFO return-address stack for the CPU control path; holds PC+1 on subroutine call and supplies the return address on return.
- Fully synchronous to clk, registered pointer, combinational top-of-stack read.
- Adds full/empty/count status, sticky overflow/underflow error flags, flush, same-cycle push+pop replace and a selectable overflow policy.

Parameters:
- WIDTH, 10, bits per entry (PC width).
- DEPTH, 8, number of entries; legal range 2..256, any integer (not restricted to powers of two).
- OVF_WRAP, 0:
  - 0 = push when full is rejected.
  - 1 = push when full overwrites the oldest entry (circular).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high.
- push  input  1  write din onto stack this cycle.
- pop  input  1  remove top entry this cycle.
- din  input  WIDTH  data to push.
- flush  input  1  synchronous clear of contents and count.
- clr_err  input  1  synchronous clear of ovf/unf.
- top  output  WIDTH  current top entry, combinational from state; 0 when empty.
- count  output  CW=$clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- ovf  output  1  sticky: a push was attempted while full.
- unf  output  1  sticky: a pop was attempted while empty.

Behaviour:
- State:
  - mem[0:DEPTH-1]
  - sp: next-free index, modulo DEPTH
  - count
  - ovf, unf
- Reset (async, high): sp=0, count=0, ovf=0, unf=0. Outputs become top=0, empty=1, full=0. mem is not cleared.
- top = mem[(sp-1) mod DEPTH] when count>0, else 0. Pop data is valid in the same cycle pop is asserted; the caller samples top before the edge.
- Priority per rising edge: flush > push/pop.
  - flush: sp=0, count=0.
  - flush does not touch ovf/unf.
  - push/pop are ignored in a flush cycle.
- push only:
  - count<DEPTH: mem[sp]<=din, sp<=sp+1 mod DEPTH, count+1.
  - full, OVF_WRAP=0: no state change, ovf<=1.
  - full, OVF_WRAP=1: mem[sp]<=din, sp<=sp+1 mod DEPTH, count stays DEPTH, ovf<=1. The oldest entry is lost.
- pop only:
  - count>0: sp<=sp-1 mod DEPTH, count-1.
  - empty: no state change, unf<=1.
- push and pop together:
  - count>0: replace top, i.e. mem[sp-1]<=din. sp and count are unchanged, no flags are set. This applies even when full.
  - empty: net no-op (push then pop). Stack stays empty, no flags, din is discarded.
- clr_err: ovf<=0, unf<=0. If an error event occurs in the same cycle, the set wins.
- Pointer arithmetic wraps explicitly at DEPTH, not at 2^bits. count never exceeds DEPTH and never underflows.
- Reset asserted mid-sequence takes effect immediately regardless of push/pop/flush.
- OVF_WRAP=1 after overflow: at most DEPTH most-recent entries can be popped. Further pops then underflow.

Test Plan (WIDTH=10, DEPTH=8):
- Reset, then push 10'h001..10'h003 on consecutive cycles → count=3, top=10'h003; three pops return 003,002,001 in order; empty=1, top=0, unf=0.
- OVF_WRAP=0: push 9 values 10'h010..10'h018 → after 8 pushes full=1; 9th push leaves count=8, top=10'h017, ovf=1. Pop all → 017..010.
- OVF_WRAP=1: push 10'h020..10'h029 (10 values) → count=8, ovf=1, top=10'h029. 8 pops return 029..022. A 9th pop sets unf=1, count stays 0.
- Push 10'h100, 10'h101, then push+pop with din=10'h1FF → count=2, top=10'h1FF; pop → top=10'h100. Push+pop while empty → count=0, ovf=0, unf=0.
- Push 5 entries, assert flush with push=1 same cycle → count=0, empty=1. Pop → unf=1. clr_err with pop on empty in same cycle → unf remains 1. clr_err alone → unf=0.
- Push 4 entries, assert reset asynchronously between clock edges → count=0, empty=1, ovf=0, unf=0 before the next edge.
